// File: rtl/fifo_rw_controller_if.sv
// Handshake and status bundle between a FIFO producer/consumer and its
// read/write sequencing controller.
interface fifo_rw_controller_if #(
  parameter int AW = 4,
  parameter int CW = 5
);
  logic          wr_req;
  logic          rd_req;
  logic          clr_err;
  logic          WriteEn;
  logic          ReadEn;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          rd_valid;
  logic          overflow;
  logic          underflow;

  modport master (
    output wr_req, rd_req, clr_err,
    input  WriteEn, ReadEn, wr_ptr, rd_ptr, count,
    input  empty, full, rd_valid, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req, clr_err,
    output WriteEn, ReadEn, wr_ptr, rd_ptr, count,
    output empty, full, rd_valid, overflow, underflow
  );
endinterface

// File: rtl/fifo_rw_controller.sv
// Sequencing controller for a register-file FIFO: accepts read/write requests,
// advances the address counters and tracks occupancy plus sticky error flags.
module fifo_rw_controller #(
  parameter int DEPTH = 15,
  parameter int AW    = 4,
  parameter int CW    = 5
) (
  input logic             clk,
  input logic             rst_n,
  fifo_rw_controller_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [AW-1:0] LastPtr    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

  state_t        stateReg, stateNext;
  logic [CW-1:0] countReg, countNext;
  logic [AW-1:0] wrPtrReg, wrPtrNext;
  logic [AW-1:0] rdPtrReg, rdPtrNext;
  logic          rdValidReg;
  logic          overflowReg, overflowNext;
  logic          underflowReg, underflowNext;
  logic          writeEn, readEn;

  always_comb begin
    writeEn       = 1'b0;
    readEn        = 1'b0;
    stateNext     = stateReg;
    countNext     = countReg;
    wrPtrNext     = wrPtrReg;
    rdPtrNext     = rdPtrReg;
    overflowNext  = overflowReg;
    underflowNext = underflowReg;

    // Accept decisions; no read-through when empty, write-through when full.
    if (rst_n) begin
      case (stateReg)
        EMPTY: begin
          writeEn = bus.wr_req;
        end
        PARTIAL: begin
          writeEn = bus.wr_req;
          readEn  = bus.rd_req;
        end
        FULL: begin
          readEn  = bus.rd_req;
          writeEn = bus.wr_req & bus.rd_req;
        end
        default: begin
        end
      endcase
    end

    if (writeEn) wrPtrNext = (wrPtrReg == LastPtr) ? '0 : wrPtrReg + AW'(1);
    if (readEn)  rdPtrNext = (rdPtrReg == LastPtr) ? '0 : rdPtrReg + AW'(1);

    if (writeEn && !readEn)      countNext = countReg + CW'(1);
    else if (readEn && !writeEn) countNext = countReg - CW'(1);

    if (countNext == '0)              stateNext = EMPTY;
    else if (countNext == DepthCount) stateNext = FULL;
    else                              stateNext = PARTIAL;

    // A refusal in the same cycle as clr_err keeps the flag set.
    overflowNext  = (bus.wr_req && !writeEn) || (overflowReg  && !bus.clr_err);
    underflowNext = (bus.rd_req && !readEn)  || (underflowReg && !bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg     <= EMPTY;
      countReg     <= '0;
      wrPtrReg     <= '0;
      rdPtrReg     <= '0;
      rdValidReg   <= 1'b0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      countReg     <= countNext;
      wrPtrReg     <= wrPtrNext;
      rdPtrReg     <= rdPtrNext;
      rdValidReg   <= readEn;
      overflowReg  <= overflowNext;
      underflowReg <= underflowNext;
    end
  end

  assign bus.WriteEn   = writeEn;
  assign bus.ReadEn    = readEn;
  assign bus.wr_ptr    = wrPtrReg;
  assign bus.rd_ptr    = rdPtrReg;
  assign bus.count     = countReg;
  assign bus.empty     = (stateReg == EMPTY);
  assign bus.full      = (stateReg == FULL);
  assign bus.rd_valid  = rdValidReg;
  assign bus.overflow  = overflowReg;
  assign bus.underflow = underflowReg;

endmodule
